prog_loader: RTL

- Writer side of the microcode program memory that the 6-bit sequencer reads each cycle.
- Accepts a byte stream over a valid/ready handshake and assembles 34-bit control words:
  - A_addr, B_addr, W_addr (4 bits each)
  - wr, imm_to_W, imm_to_B (1 bit each)
  - ALUSel (3 bits)
  - data2, data1 (8 bits each)
- Writes each word to sequential program-RAM addresses and holds the datapath in reset while loading.
- Sits between the host byte link and the program RAM write port.

---
 rtl/prog_loader_pkg.sv | 52 +++++
 rtl/prog_loader_word_assembler.sv | 72 +++++++
 rtl/prog_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the microcode program loader:
//   - geometry of the program memory and of one control word
//   - bit layout of the 34-bit control word (as a packed struct)
//   - loader FSM state encoding
//   - clamp_words(): limits a requested word count to the memory depth
// Optional feature macro used by the loader: PROG_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    localparam int ADDR_W         = 6;   // program address width
    localparam int DEPTH          = 64;  // number of program words
    localparam int WORD_W         = 34;  // control word width
    localparam int BYTES_PER_WORD = 5;   // ceil(WORD_W/8)

    localparam int CNT_W  = $clog2(BYTES_PER_WORD);
    // The last byte of a word only carries the bits above TOP_LSB.
    localparam int TOP_LSB = 8 * (BYTES_PER_WORD - 1);
    localparam int TOP_W   = WORD_W - TOP_LSB;

    localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

    // Control word layout, MSB first:
    //   A_addr 33:30, B_addr 29:26, W_addr 25:22, wr 21, imm_to_W 20,
    //   imm_to_B 19, ALUSel 18:16, data2 15:8, data1 7:0
    typedef struct packed {
        logic [3:0] a_addr;
        logic [3:0] b_addr;
        logic [3:0] w_addr;
        logic       wr;
        logic       imm_to_w;
        logic       imm_to_b;
        logic [2:0] alu_sel;
        logic [7:0] data2;
        logic [7:0] data1;
    } ctrl_word_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WRITE   = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // Requests beyond the memory depth are truncated rather than wrapped.
    function automatic logic [ADDR_W:0] clamp_words(input logic [ADDR_W:0] n);
        return (n > DEPTH_N) ? DEPTH_N : n;
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs a little-endian byte stream into one control word and keeps a running
// XOR of every payload byte seen since the last load start.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   i_clr_cnt     restart byte position at byte0 (new word)
//   i_clr_xor     clear the running XOR (new load)
//   i_take        a payload byte is accepted this cycle
//   i_byte        payload byte
//   o_word        assembled control word
//   o_last        next accepted byte is the final byte of the word
//   o_rsvd_err    final byte accepted with non-zero unused upper bits
//   o_xor         XOR of all payload bytes of the current load
// -----------------------------------------------------------------------------
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr_cnt,
    input  logic              i_clr_xor,
    input  logic              i_take,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_last,
    output logic              o_rsvd_err,
    output logic [7:0]        o_xor
);

    logic [CNT_W-1:0]  r_byte_cnt;
    logic [WORD_W-1:0] r_word;
    logic [7:0]        r_xor;

    assign o_last     = (r_byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
    assign o_rsvd_err = i_take && o_last && (|i_byte[7:TOP_W]);
    assign o_word     = r_word;
    assign o_xor      = r_xor;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_xor      <= '0;
        end else begin
            if (i_clr_cnt) begin
                r_byte_cnt <= '0;
            end else if (i_take) begin
                r_byte_cnt <= o_last ? '0 : r_byte_cnt + CNT_W'(1);
            end

            // Each byte lands in its own slot; the final byte keeps only the
            // bits that exist in the word, its upper bits are dropped.
            if (i_take) begin
                if (o_last) begin
                    r_word[WORD_W-1:TOP_LSB] <= i_byte[TOP_W-1:0];
                end else begin
                    r_word[{r_byte_cnt[1:0], 3'b000} +: 8] <= i_byte;
                end
            end

            if (i_clr_xor) begin
                r_xor <= '0;
            end else if (i_take) begin
                r_xor <= r_xor ^ i_byte;
            end
        end
    end

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Writer side of the microcode program memory. Receives bytes over a
// valid/ready link, assembles 34-bit control words and writes them to
// consecutive program-RAM addresses starting at 0, holding the core in reset
// while a load is in progress.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to expect one trailing
// XOR checksum byte after the last word (mismatch sets err).
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   start        one-cycle pulse, begins a load (ignored unless idle)
//   num_words    words to load, sampled on start, clamped to DEPTH
//   in_valid     byte valid
//   in_data      byte payload
//   in_ready     byte accepted when in_valid & in_ready
//   mem_we       program RAM write enable
//   mem_addr     program RAM write address
//   mem_wdata    assembled control word
//   core_hold    holds sequencer/register file in reset while loading
//   busy         loader not idle
//   done         one-cycle pulse at load completion
//   err          sticky error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_e S_AFTER_LAST = S_CHECK;
`else
    localparam state_e S_AFTER_LAST = S_DONE;
`endif

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_words;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    logic              w_take;
    logic              w_take_payload;
    logic              w_start_load;
    logic              w_clr_cnt;
    logic              w_last;
    logic              w_rsvd_err;
    logic              w_last_word;
    logic [7:0]        w_xor;
    ctrl_word_t        w_word;

    assign w_take         = in_valid && in_ready;
    assign w_take_payload = w_take && (r_state == S_COLLECT);
    assign w_start_load   = start && (r_state == S_IDLE);
    assign w_clr_cnt      = w_start_load || (r_state == S_WRITE);
    assign w_last_word    = ((r_words + (ADDR_W + 1)'(1)) == r_n);

`ifndef PROG_LOADER_CHECKSUM_EN
    logic [7:0] w_unused_xor;
    assign w_unused_xor = w_xor;
`endif

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_clr_cnt  (w_clr_cnt),
        .i_clr_xor  (w_start_load),
        .i_take     (w_take_payload),
        .i_byte     (in_data),
        .o_word     (w_word),
        .o_last     (w_last),
        .o_rsvd_err (w_rsvd_err),
        .o_xor      (w_xor)
    );

    assign mem_addr  = r_addr;
    assign mem_wdata = w_word;
    assign busy      = (r_state != S_IDLE);
    assign core_hold = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        mem_we   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (clamp_words(num_words) == '0) ? S_AFTER_LAST : S_COLLECT;
                end
            end
            S_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                w_next = w_last_word ? S_AFTER_LAST : S_COLLECT;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_words <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_start_load) begin
                r_n     <= clamp_words(num_words);
                r_words <= '0;
                r_addr  <= '0;
            end else if (r_state == S_WRITE) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_words <= r_words + (ADDR_W + 1)'(1);
            end

            // Start clears and the set conditions live in different states,
            // so they never collide.
            if (w_start_load) begin
                r_err <= 1'b0;
            end else if (w_take_payload && w_rsvd_err) begin
                r_err <= 1'b1;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            if (w_take && (r_state == S_CHECK) && (in_data != w_xor)) begin
                r_err <= 1'b1;
            end
`endif
        end
    end

endmodule
